// File: rtl/sha3_scanner_multilane_control.sv
// Multi-lane SHA3 nonce scanner control: dispatches nonces to LANES hashers in lockstep,
// tracks outstanding work per lane and captures the first hash meeting the difficulty bound.
module sha3_scanner_multilane_control #(
  parameter int unsigned PROPER       = 1,
  parameter int unsigned LANES        = 2,
  parameter int unsigned EXHAUST_BIT  = 29,
  parameter int unsigned MAX_INFLIGHT = 64,
  localparam int unsigned NW = (PROPER != 0) ? 20 : 24,
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [63:0]             threshold,
  input  logic [32*NW-1:0]        blockTemplate,
  output logic                    oready,
  output logic                    odispatching,
  output logic                    oevaluating,
  output logic                    ofound,
  output logic [64*25-1:0]        ohash,
  output logic [31:0]             ononce,
  output logic [LW-1:0]           olane,
  output logic [31:0]             scan_count,
  input  logic [LANES-1:0]        hasher_ready,
  output logic [LANES-1:0]        feedgood,
  output logic [LANES*25*64-1:0]  feed,
  input  logic [LANES-1:0]        hashgood,
  input  logic [LANES*25*64-1:0]  hash
);

  localparam int unsigned NONCE_WORD = (PROPER != 0) ? 19 : 21;
  localparam int unsigned TPL_LANES  = NW / 2;
  localparam int unsigned CW         = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned RW         = EXHAUST_BIT + 1;
  localparam logic [RW-1:0] ROUND_LIMIT = RW'((64'd1 << EXHAUST_BIT) / 64'(LANES));

  typedef enum logic [2:0] {
    WAITING     = 3'b001,
    DISPATCHING = 3'b010,
    FLUSHING    = 3'b100
  } state_t;

  state_t                  state;
  logic [32*NW-1:0]        tmpl;
  logic [RW-1:0]           rounds;
  logic [CW-1:0]           outst  [LANES];
  logic [31:0]             rcount [LANES];

  logic [31:0]             base;
  logic [31:0]             round_base;
  logic                    all_ready;
  logic                    stop;
  logic                    issue;
  logic                    idle;
  logic [LANES-1:0][63:0]  diff;
  logic                    hit;
  logic [LW-1:0]           hit_lane;
  logic [64*25-1:0]        hit_hash;
  logic [31:0]             hit_nonce;

  // The nonce word of the captured template doubles as the scan base.
  assign base       = tmpl[NONCE_WORD*32 +: 32];
  assign round_base = base + 32'(LANES) * 32'(rounds);
  assign all_ready  = &hasher_ready;
  assign stop       = (rounds == ROUND_LIMIT) | ofound | abort;
  assign issue      = (state == DISPATCHING) & all_ready & ~stop;

  assign feedgood     = {LANES{issue}};
  assign oready       = (state == WAITING);
  assign odispatching = (state == DISPATCHING) & all_ready;
  assign oevaluating  = |hashgood;
  assign scan_count   = 32'(64'd1 << EXHAUST_BIT);

  // Keccak input per lane: template lanes, nonce insert and padding constants.
  always_comb begin
    feed = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < TPL_LANES; j++)
        feed[(l*25+j)*64 +: 64] = tmpl[j*64 +: 64];
      if (PROPER != 0) begin
        feed[(l*25+9)*64 +: 64]  = {round_base + 32'(l), tmpl[18*32 +: 32]};
        feed[(l*25+10)*64 +: 64] = 64'd1;
      end else begin
        feed[(l*25+12)*64 +: 64] = {24'd0, 8'h06, round_base + 32'(l)};
      end
      feed[(l*25+16)*64 +: 64] = 64'h8000_0000_0000_0000;
    end
  end

  // Difficulty word per lane; the legacy format compares A0 byte-reversed.
  always_comb begin
    diff = '0;
    for (int l = 0; l < LANES; l++) begin
      if (PROPER != 0)
        diff[l] = hash[(l*25+3)*64 +: 64];
      else
        for (int b = 0; b < 8; b++)
          diff[l][b*8 +: 8] = hash[(l*25)*64 + (7-b)*8 +: 8];
    end
  end

  // Scan downwards so the lowest qualifying lane wins.
  always_comb begin
    hit       = 1'b0;
    hit_lane  = '0;
    hit_hash  = '0;
    hit_nonce = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hashgood[l] && (diff[l] <= threshold)) begin
        hit       = 1'b1;
        hit_lane  = LW'(l);
        hit_hash  = hash[l*1600 +: 1600];
        hit_nonce = base + 32'(l) + 32'(LANES) * rcount[l];
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int l = 0; l < LANES; l++)
      if (outst[l] != '0) idle = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAITING;
      tmpl   <= '0;
      rounds <= '0;
      ofound <= 1'b0;
      ohash  <= '0;
      ononce <= '0;
      olane  <= '0;
      for (int l = 0; l < LANES; l++) begin
        outst[l]  <= '0;
        rcount[l] <= '0;
      end
    end else begin
      case (state)
        WAITING: begin
          if (start) begin
            tmpl   <= blockTemplate;
            rounds <= '0;
            ofound <= 1'b0;
            ohash  <= '0;
            ononce <= '0;
            olane  <= '0;
            for (int l = 0; l < LANES; l++) rcount[l] <= '0;
            state  <= DISPATCHING;
          end
        end
        DISPATCHING: begin
          if (stop) state <= FLUSHING;
          if (issue) rounds <= rounds + RW'(1);
        end
        FLUSHING: begin
          if (idle && !(|hashgood)) state <= WAITING;
        end
        default: state <= WAITING;
      endcase

      // Result bookkeeping only while a scan is live; late returns in WAITING are dropped.
      if (state != WAITING) begin
        for (int l = 0; l < LANES; l++) begin
          if (issue && !(hashgood[l] && outst[l] != '0))
            outst[l] <= outst[l] + CW'(1);
          else if (!issue && hashgood[l] && outst[l] != '0)
            outst[l] <= outst[l] - CW'(1);
          if (hashgood[l]) rcount[l] <= rcount[l] + 32'd1;
        end
        if (!ofound && hit) begin
          ofound <= 1'b1;
          ohash  <= hit_hash;
          ononce <= hit_nonce;
          olane  <= hit_lane;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha3_scanner_multilane_control.sv
// Directed bench for the multi-lane scanner control: a 2-lane and a 4-lane instance
// driven by a hand-written hasher model.
module tb_sha3_scanner_multilane_control;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2-lane instance, 16-nonce scan
  logic           start2, abort2;
  logic [63:0]    thr2;
  logic [639:0]   tpl2;
  logic [1:0]     rdy2, hg2, fg2;
  logic [3199:0]  hash2, feed2;
  logic           ordy2, odisp2, oeval2, ofnd2;
  logic [1599:0]  ohash2;
  logic [31:0]    onon2, scan2;
  logic [0:0]     olane2;

  // 4-lane instance, 32-nonce scan
  logic           start4, abort4;
  logic [63:0]    thr4;
  logic [639:0]   tpl4;
  logic [3:0]     rdy4, hg4, fg4;
  logic [6399:0]  hash4, feed4;
  logic           ordy4, odisp4, oeval4, ofnd4;
  logic [1599:0]  ohash4;
  logic [31:0]    onon4, scan4;
  logic [1:0]     olane4;

  sha3_scanner_multilane_control #(.PROPER(1), .LANES(2), .EXHAUST_BIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .threshold(thr2),
    .blockTemplate(tpl2), .oready(ordy2), .odispatching(odisp2), .oevaluating(oeval2),
    .ofound(ofnd2), .ohash(ohash2), .ononce(onon2), .olane(olane2), .scan_count(scan2),
    .hasher_ready(rdy2), .feedgood(fg2), .feed(feed2), .hashgood(hg2), .hash(hash2));

  sha3_scanner_multilane_control #(.PROPER(1), .LANES(4), .EXHAUST_BIT(5)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .threshold(thr4),
    .blockTemplate(tpl4), .oready(ordy4), .odispatching(odisp4), .oevaluating(oeval4),
    .ofound(ofnd4), .ohash(ohash4), .ononce(onon4), .olane(olane4), .scan_count(scan4),
    .hasher_ready(rdy4), .feedgood(fg4), .feed(feed4), .hashgood(hg4), .hash(hash4));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  rdy;
    logic [1:0]  exp_fg;
    logic [63:0] exp_b4_l0;
    logic [63:0] exp_b4_l1;
  } feed_vec_t;

  feed_vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [639:0] mktpl(input logic [31:0] base);
    logic [639:0] t;
    for (int i = 0; i < 20; i++) t[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    t[19*32 +: 32] = base;
    return t;
  endfunction

  function automatic logic [1599:0] mkhash(input logic [31:0] seed, input logic [63:0] a3);
    logic [1599:0] h;
    for (int j = 0; j < 25; j++) h[j*64 +: 64] = {seed, 32'(j)};
    h[3*64 +: 64] = a3;
    return h;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lane_seq [7];
    rst = 1'b1;
    start2 = 0; abort2 = 0; thr2 = '0; tpl2 = mktpl(32'h10); rdy2 = '0; hg2 = '0; hash2 = '0;
    start4 = 0; abort4 = 0; thr4 = '0; tpl4 = '0; rdy4 = '0; hg4 = '0; hash4 = '0;

    tbl[0] = '{2'b11, 2'b11, 64'h0000_0010_A5A5_0012, 64'h0000_0011_A5A5_0012};
    tbl[1] = '{2'b01, 2'b00, 64'h0000_0012_A5A5_0012, 64'h0000_0013_A5A5_0012};
    tbl[2] = '{2'b11, 2'b11, 64'h0000_0012_A5A5_0012, 64'h0000_0013_A5A5_0012};
    tbl[3] = '{2'b11, 2'b11, 64'h0000_0014_A5A5_0012, 64'h0000_0015_A5A5_0012};
    tbl[4] = '{2'b10, 2'b00, 64'h0000_0016_A5A5_0012, 64'h0000_0017_A5A5_0012};
    tbl[5] = '{2'b11, 2'b11, 64'h0000_0016_A5A5_0012, 64'h0000_0017_A5A5_0012};
    tbl[6] = '{2'b11, 2'b11, 64'h0000_0018_A5A5_0012, 64'h0000_0019_A5A5_0012};
    tbl[7] = '{2'b11, 2'b11, 64'h0000_001A_A5A5_0012, 64'h0000_001B_A5A5_0012};
    tbl[8] = '{2'b11, 2'b11, 64'h0000_001C_A5A5_0012, 64'h0000_001D_A5A5_0012};
    tbl[9] = '{2'b11, 2'b11, 64'h0000_001E_A5A5_0012, 64'h0000_001F_A5A5_0012};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_oready2", 64'(ordy2), 64'd1);
    chk("rst_ofound2", 64'(ofnd2), 64'd0);
    chk("rst_feedgood2", 64'(fg2), 64'd0);
    chk("rst_ononce2", 64'(onon2), 64'd0);
    chk("scan_count2", 64'(scan2), 64'd16);
    chk("scan_count4", 64'(scan4), 64'd32);
    chk("rst_oready4", 64'(ordy4), 64'd1);

    // Full 16-nonce scan on two lanes, no qualifying hash
    start2 = 1'b1;
    nxt();
    start2 = 1'b0;
    #1;
    chk("a0_tpl", feed2[0 +: 64], 64'hA5A5_0001_A5A5_0000);
    chk("c0_pad", feed2[10*64 +: 64], 64'd1);
    chk("c1_zero", feed2[11*64 +: 64], 64'd0);
    chk("d1_pad_l1", feed2[(25+16)*64 +: 64], 64'h8000_0000_0000_0000);
    chk("odisp_notready", 64'(odisp2), 64'd0);
    for (int i = 0; i < 10; i++) begin
      rdy2 = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_feedgood", i), 64'(fg2), 64'(tbl[i].exp_fg));
      chk($sformatf("vec%0d_b4_l0", i), feed2[9*64 +: 64], tbl[i].exp_b4_l0);
      chk($sformatf("vec%0d_b4_l1", i), feed2[(25+9)*64 +: 64], tbl[i].exp_b4_l1);
      nxt();
    end
    rdy2 = 2'b11;
    #1;
    chk("exhaust_feedgood", 64'(fg2), 64'd0);
    chk("exhaust_oready", 64'(ordy2), 64'd0);
    nxt();
    chk("flush_odisp", 64'(odisp2), 64'd0);
    for (int k = 0; k < 8; k++) begin
      hg2 = 2'b11;
      hash2 = {mkhash(32'(2*k+1), 64'h5), mkhash(32'(2*k), 64'h5)};
      #1;
      chk("flush_oeval", 64'(oeval2), 64'd1);
      nxt();
    end
    hg2 = '0;
    #1;
    chk("flush_last_oready", 64'(ordy2), 64'd0);
    nxt();
    chk("scanA_oready", 64'(ordy2), 64'd1);
    chk("scanA_ofound", 64'(ofnd2), 64'd0);

    // Nonce wrap, abort with 7 outstanding, hit during flush
    rdy2 = '0;
    tpl2 = mktpl(32'hFFFF_FFFE);
    start2 = 1'b1;
    nxt();
    start2 = 1'b0;
    rdy2 = 2'b11;
    #1;
    chk("wrap_r0_l0", feed2[9*64 +: 64], 64'hFFFF_FFFE_A5A5_0012);
    chk("wrap_r0_l1", feed2[(25+9)*64 +: 64], 64'hFFFF_FFFF_A5A5_0012);
    nxt();
    chk("wrap_r1_l0", feed2[9*64 +: 64], 64'h0000_0000_A5A5_0012);
    chk("wrap_r1_l1", feed2[(25+9)*64 +: 64], 64'h0000_0001_A5A5_0012);
    repeat (4) nxt();
    rdy2 = '0;
    hash2 = {mkhash(32'h11, 64'h5), mkhash(32'h10, 64'h5)};
    hg2 = 2'b01; nxt();
    hg2 = 2'b10; nxt();
    hg2 = 2'b01; nxt();
    hg2 = '0;
    abort2 = 1'b1;
    rdy2 = 2'b11;
    #1;
    chk("abort_feedgood", 64'(fg2), 64'd0);
    nxt();
    abort2 = 1'b0;
    chk("abort_oready", 64'(ordy2), 64'd0);
    chk("abort_flush_feedgood", 64'(fg2), 64'd0);
    lane_seq = '{0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      hg2 = (lane_seq[i] == 0) ? 2'b01 : 2'b10;
      if (i == 4)      hash2 = {mkhash(32'h55, 64'h0), mkhash(32'h50, 64'h5)};
      else if (i == 5) hash2 = {mkhash(32'h66, 64'h0), mkhash(32'h60, 64'h5)};
      else             hash2 = {mkhash(32'h77, 64'h5), mkhash(32'h70, 64'h5)};
      #1;
      chk($sformatf("abort_ret%0d_oready", i), 64'(ordy2), 64'd0);
      nxt();
    end
    hg2 = '0;
    #1;
    chk("abort_idle_oready", 64'(ordy2), 64'd0);
    nxt();
    chk("abort_done_oready", 64'(ordy2), 64'd1);
    chk("flushhit_ofound", 64'(ofnd2), 64'd1);
    chk("flushhit_ononce", 64'(onon2), 64'h3);
    chk("flushhit_olane", 64'(olane2), 64'd1);
    chk("flushhit_ohash", 64'(ohash2 == mkhash(32'h55, 64'h0)), 64'd1);

    // Four lanes: lane 2 hits on its round 3
    tpl4 = mktpl(32'h100);
    thr4 = 64'h1000;
    start4 = 1'b1;
    nxt();
    start4 = 1'b0;
    rdy4 = 4'hF;
    repeat (3) nxt();
    chk("l4_r3_b4_l2", feed4[(2*25+9)*64 +: 64], 64'h0000_010E_A5A5_0012);
    nxt();
    rdy4 = '0;
    for (int k = 0; k < 3; k++) begin
      hg4 = 4'hF;
      hash4 = {mkhash(32'h3, 64'hFFFF), mkhash(32'h2, 64'hFFFF),
               mkhash(32'h1, 64'hFFFF), mkhash(32'h0, 64'hFFFF)};
      nxt();
    end
    hg4 = 4'b0101;
    hash4 = {mkhash(32'h23, 64'h0), mkhash(32'h22, 64'h0FFF),
             mkhash(32'h21, 64'h0), mkhash(32'h20, 64'hFFFF)};
    nxt();
    hg4 = '0;
    rdy4 = 4'hF;
    #1;
    chk("l4_ofound", 64'(ofnd4), 64'd1);
    chk("l4_ononce", 64'(onon4), 64'h10E);
    chk("l4_olane", 64'(olane4), 64'd2);
    chk("l4_ohash", 64'(ohash4 == mkhash(32'h22, 64'h0FFF)), 64'd1);
    chk("l4_found_feedgood", 64'(fg4), 64'd0);
    chk("l4_found_odisp", 64'(odisp4), 64'd1);
    nxt();
    hg4 = 4'b1010;
    hash4 = {mkhash(32'h43, 64'h0), mkhash(32'h42, 64'h0),
             mkhash(32'h41, 64'h0), mkhash(32'h40, 64'h0)};
    nxt();
    hg4 = '0;
    rdy4 = '0;
    nxt();
    chk("l4_done_oready", 64'(ordy4), 64'd1);
    chk("l4_hold_olane", 64'(olane4), 64'd2);
    chk("l4_hold_ononce", 64'(onon4), 64'h10E);

    // Simultaneous hits on lanes 1 and 3: lowest lane wins
    tpl4 = mktpl(32'h2000);
    start4 = 1'b1;
    nxt();
    start4 = 1'b0;
    #1;
    chk("s2_clear_ofound", 64'(ofnd4), 64'd0);
    chk("s2_clear_ononce", 64'(onon4), 64'd0);
    chk("s2_clear_olane", 64'(olane4), 64'd0);
    rdy4 = 4'hF;
    nxt();
    rdy4 = '0;
    hg4 = 4'hF;
    hash4 = {mkhash(32'h33, 64'h10), mkhash(32'h32, 64'hFFFF),
             mkhash(32'h31, 64'h10), mkhash(32'h30, 64'hFFFF)};
    #1;
    chk("s2_oeval", 64'(oeval4), 64'd1);
    nxt();
    hg4 = '0;
    #1;
    chk("s2_ofound", 64'(ofnd4), 64'd1);
    chk("s2_olane", 64'(olane4), 64'd1);
    chk("s2_ononce", 64'(onon4), 64'h2001);
    chk("s2_ohash", 64'(ohash4 == mkhash(32'h31, 64'h10)), 64'd1);
    nxt();
    nxt();
    chk("s2_done_oready", 64'(ordy4), 64'd1);

    // Asynchronous reset in the middle of DISPATCHING
    tpl4 = mktpl(32'h3000);
    start4 = 1'b1;
    nxt();
    start4 = 1'b0;
    rdy4 = 4'hF;
    nxt();
    nxt();
    rdy4 = '0;
    hg4 = 4'b0001;
    hash4 = {mkhash(32'h53, 64'hFFFF), mkhash(32'h52, 64'hFFFF),
             mkhash(32'h51, 64'hFFFF), mkhash(32'h50, 64'h0)};
    nxt();
    hg4 = '0;
    rdy4 = 4'hF;
    #1;
    chk("pre_rst_ofound", 64'(ofnd4), 64'd1);
    chk("pre_rst_ononce", 64'(onon4), 64'h3000);
    chk("pre_rst_odisp", 64'(odisp4), 64'd1);
    chk("pre_rst_oready", 64'(ordy4), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_oready", 64'(ordy4), 64'd1);
    chk("async_rst_ofound", 64'(ofnd4), 64'd0);
    chk("async_rst_ononce", 64'(onon4), 64'd0);
    chk("async_rst_feedgood", 64'(fg4), 64'd0);
    chk("async_rst_odisp", 64'(odisp4), 64'd0);
    #1 rst = 1'b0;
    rdy4 = '0;
    nxt();
    hg4 = 4'b0010;
    hash4 = {mkhash(32'h63, 64'h0), mkhash(32'h62, 64'h0),
             mkhash(32'h61, 64'h0), mkhash(32'h60, 64'h0)};
    nxt();
    hg4 = '0;
    #1;
    chk("late_ret_ofound", 64'(ofnd4), 64'd0);
    chk("late_ret_oready", 64'(ordy4), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
